// File: rtl/conv3x3_pkg.sv
// Shared types and sizing for the 3x3 convolution accelerator.
// Tile is IN_NUM_OF_SET rows of DATA_OF_SET words; results land in a circular row buffer.
package conv3x3_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int BUFFER_SIZE    = 32;
   localparam int KERNEL_SIZE    = 9;
   localparam int NUM_OF_MUL     = 14;
   localparam int DATA_OF_SET    = 128;
   localparam int IN_NUM_OF_SET  = 16;
   localparam int OUT_NUM_OF_SET = 3;
   localparam int RD_ROWS        = 8;
   localparam int PTR_W          = $clog2(BUFFER_SIZE);
   localparam int CNT_W          = $clog2(BUFFER_SIZE + 1);
   localparam int ROW_W          = $clog2(IN_NUM_OF_SET);

   typedef logic [DATA_WIDTH-1:0]    word_t;
   typedef word_t [DATA_OF_SET-1:0]  row_t;
   typedef word_t [KERNEL_SIZE-1:0]  kernel_t;

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_READ} state_t;

   localparam logic [1:0] OP_IDLE  = 2'd0;
   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;
endpackage

// File: rtl/conv3x3_accel_pe.sv
// One output row of the 3x3 convolution: products, per-kernel-row sums, final sum.
// The final sum is combinational off stage 1 so the caller can register it as stage 2.
module conv_row_pe
   import conv3x3_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  row_t [2:0]                win,
   input  kernel_t                   kern,
   input  logic                      vld_in,
   output row_t                      sum_row,
   output logic                      sum_vld,
   output logic [OUT_NUM_OF_SET-1:0] stage_vld
);
   // vld_pipe[s+1] is the valid of stage s
   logic [OUT_NUM_OF_SET:1] vld_pipe;

   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[OUT_NUM_OF_SET-1:1], vld_in};
   end

   assign stage_vld = vld_pipe;
   assign sum_vld   = vld_pipe[2];

   for (genvar c = 0; c < DATA_OF_SET; c++) begin : g_col
      word_t prod_d [KERNEL_SIZE];
      word_t prod_q [KERNEL_SIZE];
      word_t psum_q [3];

      // taps that fall past the right edge of the tile read as zero
      for (genvar t = 0; t < KERNEL_SIZE; t++) begin : g_tap
         if (c + t % 3 < DATA_OF_SET) begin : g_in
            assign prod_d[t] = kern[t] * win[t / 3][c + t % 3];
         end else begin : g_pad
            assign prod_d[t] = '0;
         end
      end

      always_ff @(posedge clk) begin
         prod_q <= prod_d;
         for (int i = 0; i < 3; i++)
            psum_q[i] <= prod_q[3*i] + prod_q[3*i+1] + prod_q[3*i+2];
      end

      assign sum_row[c] = psum_q[0] + psum_q[1] + psum_q[2];
   end
endmodule

// File: rtl/conv3x3_accel.sv
// 3x3 convolution accelerator top: command FSM, tile/kernel latch, row counter,
// circular result buffer and 8-row readout.
module conv3x3_accel
   import conv3x3_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  row_t [IN_NUM_OF_SET-1:0]        din,
   input  kernel_t                         kernel,
   input  logic [1:0]                      op,
   output row_t [RD_ROWS-1:0]              dout,
   output logic                            dout_valid,
   output logic [RD_ROWS-1:0]              res_valid_checker,
   output logic [OUT_NUM_OF_SET-1:0]       adder_tree_valid_checker,
   output logic [1:0]                      op_reg_checker
);
   state_t                   state;
   row_t [IN_NUM_OF_SET-1:0] tile_q;
   kernel_t                  kern_q;
   logic [ROW_W-1:0]         k, kk;
   row_t                     rbuf [BUFFER_SIZE];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count;

   row_t [2:0]               win;
   logic                     pe_in_vld, pe_out_vld;
   row_t                     pe_row;
   logic [OUT_NUM_OF_SET-1:0] stage_vld;

   logic [3:0]               n_rd;
   row_t [RD_ROWS-1:0]       rd_rows;
   logic [RD_ROWS-1:0]       rd_mask;

   // clamp the window index once the row counter has run past the last output row
   always_comb begin
      kk        = (k < ROW_W'(NUM_OF_MUL)) ? k : '0;
      pe_in_vld = (state == S_COMPUTE) && (k < ROW_W'(NUM_OF_MUL));
      for (int i = 0; i < 3; i++) win[i] = tile_q[kk + ROW_W'(i)];
   end

   conv_row_pe u_pe (
      .clk       (clk),
      .rst       (rst),
      .win       (win),
      .kern      (kern_q),
      .vld_in    (pe_in_vld),
      .sum_row   (pe_row),
      .sum_vld   (pe_out_vld),
      .stage_vld (stage_vld)
   );

   assign adder_tree_valid_checker = stage_vld;

   always_comb begin
      n_rd    = (count >= CNT_W'(RD_ROWS)) ? 4'(RD_ROWS) : 4'(count);
      rd_mask = RD_ROWS'((9'd1 << n_rd) - 9'd1);
      for (int i = 0; i < RD_ROWS; i++)
         rd_rows[i] = (4'(i) < n_rd) ? rbuf[rd_ptr + PTR_W'(i)] : '0;
   end

   // buffer storage carries no reset; emptiness is tracked by count
   always_ff @(posedge clk) begin
      if (!rst && state == S_COMPUTE && pe_out_vld) rbuf[wr_ptr] <= pe_row;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         tile_q            <= '0;
         kern_q            <= '0;
         k                 <= '0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         dout              <= '0;
         dout_valid        <= 1'b0;
         res_valid_checker <= '0;
         op_reg_checker    <= OP_IDLE;
      end else begin
         op_reg_checker <= op;
         case (state)
            S_IDLE: begin
               k <= '0;
               if (op == OP_LOAD && count <= CNT_W'(BUFFER_SIZE - NUM_OF_MUL)) begin
                  tile_q <= din;
                  kern_q <= kernel;
                  state  <= S_COMPUTE;
               end else if (op == OP_READ && count != '0) begin
                  state <= S_READ;
               end else if (op == OP_CLEAR) begin
                  count  <= '0;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end
            end
            S_COMPUTE: begin
               if (k < ROW_W'(NUM_OF_MUL)) k <= k + ROW_W'(1);
               if (pe_out_vld) begin
                  wr_ptr <= wr_ptr + PTR_W'(1);
                  count  <= count + CNT_W'(1);
                  // last row is being written when nothing is left behind it
                  if (!stage_vld[0]) state <= S_IDLE;
               end
            end
            S_READ: begin
               if (count != '0) begin
                  dout              <= rd_rows;
                  dout_valid        <= 1'b1;
                  res_valid_checker <= rd_mask;
                  rd_ptr            <= rd_ptr + PTR_W'(n_rd);
                  count             <= count - CNT_W'(n_rd);
               end else begin
                  dout              <= '0;
                  dout_valid        <= 1'b0;
                  res_valid_checker <= '0;
                  state             <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv3x3_accel.sv
// Bench for conv3x3_accel: vector table of load/read scenarios with a row scoreboard,
// plus hand sequences for pipeline valid timing, ignored ops, clear and reset mid-readout.
module tb_conv3x3_accel;
   import conv3x3_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   row_t [IN_NUM_OF_SET-1:0] din;
   kernel_t                  kernel;
   logic [1:0]               op;
   row_t [RD_ROWS-1:0]       dout;
   logic                     dout_valid;
   logic [RD_ROWS-1:0]       res_valid_checker;
   logic [OUT_NUM_OF_SET-1:0] atv;
   logic [1:0]               op_reg_checker;

   conv3x3_accel dut (
      .clk                      (clk),
      .rst                      (rst),
      .din                      (din),
      .kernel                   (kernel),
      .op                       (op),
      .dout                     (dout),
      .dout_valid               (dout_valid),
      .res_valid_checker        (res_valid_checker),
      .adder_tree_valid_checker (atv),
      .op_reg_checker           (op_reg_checker)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          pat;
      int          kpat;
      int          nloads;
      int          nb;
      logic [31:0] masks;
      int          s1r, s1c;
      word_t       s1v;
      int          s2r, s2c;
      word_t       s2v;
   } vec_t;

   vec_t vecs [4];
   row_t q [$];
   int   exp_cnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_row(input string name, input row_t act, input row_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         for (int c = 0; c < DATA_OF_SET; c++)
            if (act[c] !== exp[c]) begin
               $display("FAIL %s: col %0d got %0h want %0h (t=%0t)", name, c, act[c], exp[c], $time);
               break;
            end
      end
   endtask

   // direct convolution of the current din/kernel, 32-bit wrapping
   function automatic row_t model_row(input int r);
      row_t  o;
      word_t acc;
      for (int c = 0; c < DATA_OF_SET; c++) begin
         acc = '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               if (c + j < DATA_OF_SET) acc = acc + kernel[3*i+j] * din[r+i][c+j];
         o[c] = acc;
      end
      return o;
   endfunction

   task automatic set_tile(input int pat);
      for (int r = 0; r < IN_NUM_OF_SET; r++)
         for (int c = 0; c < DATA_OF_SET; c++)
            case (pat)
               0:       din[r][c] = (c < 126) ? 32'd1 : 32'd0;
               1:       din[r][c] = (c < 126) ? word_t'(r) : 32'd0;
               default: din[r][c] = $urandom();
            endcase
   endtask

   task automatic set_kernel(input int kpat);
      for (int t = 0; t < KERNEL_SIZE; t++)
         kernel[t] = (kpat == 0) ? 32'd1 : $urandom();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      op  = OP_IDLE;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      exp_cnt = 0;
   endtask

   // one-cycle command; model bookkeeping happens as the op is driven
   task automatic op_pulse(input logic [1:0] v);
      @(negedge clk);
      op = v;
      if (v == OP_LOAD && exp_cnt <= BUFFER_SIZE - NUM_OF_MUL) begin
         for (int r = 0; r < NUM_OF_MUL; r++) q.push_back(model_row(r));
         exp_cnt += NUM_OF_MUL;
      end
      if (v == OP_CLEAR) begin
         q.delete();
         exp_cnt = 0;
      end
      @(negedge clk);
      op = OP_IDLE;
      chk("op_reg", op_reg_checker, v);
      if (v == OP_LOAD) set_tile(2);
   endtask

   task automatic drain(input int nb, input logic [31:0] masks,
                        input int s1r, input int s1c, input word_t s1v,
                        input int s2r, input int s2c, input word_t s2v);
      int   b = 0;
      row_t e;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (dout_valid) begin
            if (b < 4) chk("beat_mask", res_valid_checker, masks[8*b +: 8]);
            for (int i = 0; i < RD_ROWS; i++) begin
               if (res_valid_checker[i]) begin
                  if (q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL extra_row: beat %0d row %0d with empty scoreboard", b, i);
                  end else begin
                     e = q.pop_front();
                     chk_row("row_data", dout[i], e);
                  end
               end else begin
                  chk_row("row_zero", dout[i], '0);
               end
            end
            if (b == 0 && s1r >= 0) chk("spot_beat1", dout[s1r][s1c], s1v);
            if (b == 1 && s2r >= 0) chk("spot_beat2", dout[s2r][s2c], s2v);
            b++;
         end
      end
      chk("beat_count", b, nb);
      chk("rows_left", q.size(), 0);
      chk("end_valid", dout_valid, 0);
      chk("end_mask", res_valid_checker, 0);
      exp_cnt = 0;
      q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0] exp_atv;
      vecs[0] = '{0, 0, 1, 2, 32'h0000_3FFF, 0, 124, 32'd6,  5, 125, 32'd3};
      vecs[1] = '{1, 0, 1, 2, 32'h0000_3FFF, 7, 0,   32'd72, 5, 0,   32'd126};
      vecs[2] = '{2, 1, 1, 2, 32'h0000_3FFF, -1, 0,  32'd0,  -1, 0,  32'd0};
      vecs[3] = '{2, 1, 3, 4, 32'h0FFF_FFFF, -1, 0,  32'd0,  -1, 0,  32'd0};

      rst    = 1'b1;
      op     = OP_IDLE;
      din    = '0;
      kernel = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", dout_valid, 0);
      chk("rst_mask", res_valid_checker, 0);
      chk("rst_atv", atv, 0);
      chk("rst_opreg", op_reg_checker, 0);
      chk("rst_dout_zero", (dout == '0), 1);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_valid", dout_valid, 0);
      end

      // read on an empty buffer
      op_pulse(OP_READ);
      drain(0, 32'h0, -1, 0, 32'd0, -1, 0, 32'd0);

      foreach (vecs[v]) begin
         do_reset();
         set_kernel(vecs[v].kpat);
         for (int l = 0; l < vecs[v].nloads; l++) begin
            set_tile(vecs[v].pat);
            op_pulse(OP_LOAD);
            repeat (20) @(negedge clk);
         end
         repeat (10) @(negedge clk);
         op_pulse(OP_READ);
         drain(vecs[v].nb, vecs[v].masks, vecs[v].s1r, vecs[v].s1c, vecs[v].s1v,
               vecs[v].s2r, vecs[v].s2c, vecs[v].s2v);
      end

      // pipeline valid timeline, with a read attempted mid-compute
      do_reset();
      set_kernel(0);
      set_tile(0);
      op_pulse(OP_LOAD);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         exp_atv = {n >= 3 && n <= 16, n >= 2 && n <= 15, n >= 1 && n <= 14};
         chk("atv_timeline", atv, exp_atv);
         chk("compute_no_beat", dout_valid, 0);
         if (n == 4) op = OP_READ;
         if (n == 5) op = OP_IDLE;
      end
      op_pulse(OP_READ);
      drain(2, 32'h0000_3FFF, 0, 124, 32'd6, 5, 125, 32'd3);

      // clear then read yields nothing
      set_tile(1);
      op_pulse(OP_LOAD);
      repeat (20) @(negedge clk);
      op_pulse(OP_CLEAR);
      op_pulse(OP_READ);
      drain(0, 32'h0, -1, 0, 32'd0, -1, 0, 32'd0);

      // reset in the middle of a readout
      set_tile(1);
      op_pulse(OP_LOAD);
      repeat (20) @(negedge clk);
      op_pulse(OP_READ);
      @(negedge clk);
      chk("mid_read_valid", dout_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_read_valid", dout_valid, 0);
      chk("rst_read_mask", res_valid_checker, 0);
      rst = 1'b0;
      q.delete();
      exp_cnt = 0;
      op_pulse(OP_READ);
      drain(0, 32'h0, -1, 0, 32'd0, -1, 0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
